// File: rtl/display_board_ram_pkg.sv
// Shared cell codes, sizes and clear-FSM state type for the display board RAM.
package display_board_ram_pkg;

  localparam int ADDR_W = 6;
  localparam int CELL_W = 2;
  localparam int CNT_W  = 7;
  localparam int DEPTH  = 64;

  // Cell codes: bit 1 = red stone, bit 0 = green stone.
  localparam logic [CELL_W-1:0] CELL_EMPTY = 2'b00;
  localparam logic [CELL_W-1:0] CELL_RED   = 2'b10;
  localparam logic [CELL_W-1:0] CELL_GREEN = 2'b01;
  localparam logic [CELL_W-1:0] CELL_BAD   = 2'b11;

  localparam logic [ADDR_W-1:0] LAST_ADDR = 6'd63;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // A code may be stored only if it is not the "both stones" pattern.
  function automatic logic cell_is_valid(input logic [CELL_W-1:0] code);
    return (code != CELL_BAD);
  endfunction

endpackage

// File: rtl/display_board_ram_counter.sv
// Running red/green stone counts, updated from the old and new code of each cell write.
module board_stone_counter
  import display_board_ram_pkg::*;
(
  input  logic              clk,
  input  logic [CELL_W-1:0] old_code,
  input  logic [CELL_W-1:0] new_code,
  input  logic              update,
  input  logic              zero,
  output logic [CNT_W-1:0]  red_count,
  output logic [CNT_W-1:0]  green_count
);

  logic [CNT_W-1:0] red_r;
  logic [CNT_W-1:0] green_r;
  logic [CNT_W-1:0] red_s;
  logic [CNT_W-1:0] green_s;

  // Remove the old code's colour and add the new code's colour; a rewrite of the same code is a no-op.
  always_comb begin
    red_s   = red_r;
    green_s = green_r;
    if (update && (old_code != new_code)) begin
      case (old_code)
        CELL_RED:   red_s   = red_s - 7'd1;
        CELL_GREEN: green_s = green_s - 7'd1;
        default:    red_s   = red_s;
      endcase
      case (new_code)
        CELL_RED:   red_s   = red_s + 7'd1;
        CELL_GREEN: green_s = green_s + 7'd1;
        default:    green_s = green_s;
      endcase
    end else begin
      red_s   = red_r;
      green_s = green_r;
    end
  end

  // Count registers; zero has priority over any update in the same cycle.
  always_ff @(posedge clk) begin
    if (zero) begin
      red_r   <= 7'd0;
      green_r <= 7'd0;
    end else begin
      red_r   <= red_s;
      green_r <= green_s;
    end
  end

  assign red_count   = red_r;
  assign green_count = green_r;

endmodule

// File: rtl/display_board_ram.sv
// 64x2 game-board RAM with two registered read ports, one write port shared
// between game logic and a 64-cycle clear sequencer, and live stone counts.
module display_board_ram
  import display_board_ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CELL_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              wr_err,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done,
  input  logic [ADDR_W-1:0] ram_rd_addr,
  output logic [CELL_W-1:0] ram_data,
  input  logic [ADDR_W-1:0] qry_addr,
  output logic [CELL_W-1:0] qry_data,
  output logic [CNT_W-1:0]  red_count,
  output logic [CNT_W-1:0]  green_count
);

  logic [CELL_W-1:0] mem [0:DEPTH-1];

  clr_state_e        state_r;
  clr_state_e        state_s;
  logic [ADDR_W-1:0] clr_addr_r;
  logic [ADDR_W-1:0] clr_addr_s;
  logic              clear_done_r;
  logic              wr_err_r;
  logic [CELL_W-1:0] ram_data_r;
  logic [CELL_W-1:0] qry_data_r;

  logic              wr_acc_s;
  logic              wr_valid_s;
  logic              zero_s;
  logic [CELL_W-1:0] old_code_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [CELL_W-1:0] mem_wdata_s;

  assign busy       = (state_r == ST_CLEAR);
  assign wr_ready   = ~busy;
  assign wr_acc_s   = wr_en & wr_ready;
  assign wr_valid_s = wr_acc_s & cell_is_valid(wr_data);
  assign old_code_s = mem[wr_addr];
  // Counts are forced to zero on reset, on the clear request edge and throughout the clear.
  assign zero_s     = rst | busy | clear_req;

  // Clear FSM next-state: IDLE waits for a request, CLEAR walks the address counter to 63.
  always_comb begin
    state_s    = state_r;
    clr_addr_s = clr_addr_r;
    case (state_r)
      ST_IDLE: begin
        if (clear_req) begin
          state_s    = ST_CLEAR;
          clr_addr_s = 6'd0;
        end else begin
          state_s    = ST_IDLE;
          clr_addr_s = clr_addr_r;
        end
      end
      ST_CLEAR: begin
        clr_addr_s = clr_addr_r + 6'd1;
        if (clr_addr_r == LAST_ADDR) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_CLEAR;
        end
      end
      default: begin
        state_s    = ST_CLEAR;
        clr_addr_s = 6'd0;
      end
    endcase
  end

  // FSM state, clear address and status pulses; reset starts a fresh clear from address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_CLEAR;
      clr_addr_r   <= 6'd0;
      clear_done_r <= 1'b0;
      wr_err_r     <= 1'b0;
    end else begin
      state_r      <= state_s;
      clr_addr_r   <= clr_addr_s;
      clear_done_r <= (state_r == ST_CLEAR) && (clr_addr_r == LAST_ADDR);
      wr_err_r     <= wr_acc_s & ~cell_is_valid(wr_data);
    end
  end

  // Single write port: the clear sequencer owns it while busy, otherwise valid game writes.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = wr_addr;
    mem_wdata_s = wr_data;
    if (state_r == ST_CLEAR) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_addr_r;
      mem_wdata_s = CELL_EMPTY;
    end else if (wr_valid_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = wr_addr;
      mem_wdata_s = wr_data;
    end else begin
      mem_we_s    = 1'b0;
    end
  end

  // Storage array; contents are never reset directly, the post-reset clear empties them.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Two independent registered read ports; they see the pre-write contents of the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_data_r <= CELL_EMPTY;
      qry_data_r <= CELL_EMPTY;
    end else begin
      ram_data_r <= mem[ram_rd_addr];
      qry_data_r <= mem[qry_addr];
    end
  end

  board_stone_counter u_counter (
    .clk         (clk),
    .old_code    (old_code_s),
    .new_code    (wr_data),
    .update      (wr_valid_s),
    .zero        (zero_s),
    .red_count   (red_count),
    .green_count (green_count)
  );

  assign clear_done = clear_done_r;
  assign wr_err     = wr_err_r;
  assign ram_data   = ram_data_r;
  assign qry_data   = qry_data_r;

endmodule

// File: tb/tb_display_board_ram.sv
// Directed, table-driven bench for display_board_ram.
module tb_display_board_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [1:0] wr_data;
  logic       wr_ready;
  logic       wr_err;
  logic       clear_req;
  logic       busy;
  logic       clear_done;
  logic [5:0] ram_rd_addr;
  logic [1:0] ram_data;
  logic [5:0] qry_addr;
  logic [1:0] qry_data;
  logic [6:0] red_count;
  logic [6:0] green_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       we;
    logic [5:0] addr;
    logic [1:0] data;
    logic [5:0] qa;
    logic [1:0] exp_q;
    int         exp_red;
    int         exp_green;
    logic       exp_err;
  } vec_t;

  vec_t vecs [10];

  display_board_ram dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .wr_err      (wr_err),
    .clear_req   (clear_req),
    .busy        (busy),
    .clear_done  (clear_done),
    .ram_rd_addr (ram_rd_addr),
    .ram_data    (ram_data),
    .qry_addr    (qry_addr),
    .qry_data    (qry_data),
    .red_count   (red_count),
    .green_count (green_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_cell(input logic [5:0] a, input logic [1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // Starts at a negedge where busy should already be high (that sample is cycle 1).
  // Optionally pulses clear_req at cycle req_at and holds rst for two cycles from rst_at.
  task automatic run_clear(input int req_at, input int rst_at, output int busy_cnt, output int done_cnt);
    busy_cnt = busy ? 1 : 0;
    done_cnt = 0;
    for (int i = 1; i <= 130; i++) begin
      rst       = (rst_at > 0) && ((i == rst_at) || (i == rst_at + 1));
      clear_req = (i == req_at);
      tick();
      if (rst) begin
        busy_cnt = busy ? 1 : 0;
        done_cnt = 0;
      end else begin
        busy_cnt += busy ? 1 : 0;
        done_cnt += clear_done ? 1 : 0;
      end
    end
    rst       = 1'b0;
    clear_req = 1'b0;
  endtask

  initial begin
    int bc;
    int dc;

    vecs[0] = '{1'b1, 6'h09, 2'b10, 6'h09, 2'b00, 1, 0, 1'b0};
    vecs[1] = '{1'b1, 6'h09, 2'b01, 6'h09, 2'b10, 0, 1, 1'b0};
    vecs[2] = '{1'b0, 6'h00, 2'b00, 6'h09, 2'b01, 0, 1, 1'b0};
    vecs[3] = '{1'b1, 6'h05, 2'b11, 6'h05, 2'b00, 0, 1, 1'b1};
    vecs[4] = '{1'b0, 6'h00, 2'b00, 6'h05, 2'b00, 0, 1, 1'b0};
    vecs[5] = '{1'b1, 6'h12, 2'b10, 6'h00, 2'b00, 1, 1, 1'b0};
    vecs[6] = '{1'b1, 6'h12, 2'b10, 6'h12, 2'b10, 1, 1, 1'b0};
    vecs[7] = '{1'b1, 6'h09, 2'b00, 6'h09, 2'b01, 1, 0, 1'b0};
    vecs[8] = '{1'b1, 6'h3F, 2'b01, 6'h3F, 2'b00, 1, 1, 1'b0};
    vecs[9] = '{1'b1, 6'h3F, 2'b10, 6'h3F, 2'b01, 2, 0, 1'b0};

    rst         = 1'b1;
    wr_en       = 1'b0;
    wr_addr     = 6'd0;
    wr_data     = 2'b00;
    clear_req   = 1'b0;
    ram_rd_addr = 6'd0;
    qry_addr    = 6'd0;

    // Reset state
    @(negedge clk);
    repeat (3) tick();
    chk("rst_busy", busy, 1);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_red", red_count, 0);
    chk("rst_green", green_count, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_clear_done", clear_done, 0);
    chk("rst_ram_data", ram_data, 0);
    chk("rst_qry_data", qry_data, 0);

    // Post-reset clear: 64 busy cycles, one done pulse
    run_clear(0, 0, bc, dc);
    chk("init_busy_cycles", bc, 64);
    chk("init_done_pulses", dc, 1);
    chk("init_wr_ready", wr_ready, 1);

    // Every cell reads empty
    for (int a = 0; a < 64; a++) begin
      qry_addr = a[5:0];
      tick();
      chk($sformatf("init_qry_%0d", a), qry_data, 0);
    end
    chk("init_red", red_count, 0);
    chk("init_green", green_count, 0);

    // Vector table: write + query each cycle, query shows the pre-write value
    for (int i = 0; i < 10; i++) begin
      wr_en    = vecs[i].we;
      wr_addr  = vecs[i].addr;
      wr_data  = vecs[i].data;
      qry_addr = vecs[i].qa;
      tick();
      chk($sformatf("vec%0d_qry", i), qry_data, vecs[i].exp_q);
      chk($sformatf("vec%0d_red", i), red_count, vecs[i].exp_red);
      chk($sformatf("vec%0d_green", i), green_count, vecs[i].exp_green);
      chk($sformatf("vec%0d_err", i), wr_err, vecs[i].exp_err);
    end
    wr_en = 1'b0;

    // Read-before-write on the scanner port
    wr_en       = 1'b1;
    wr_addr     = 6'h12;
    wr_data     = 2'b01;
    ram_rd_addr = 6'h12;
    tick();
    wr_en = 1'b0;
    chk("rbw_first", ram_data, 2);
    tick();
    chk("rbw_second", ram_data, 1);
    chk("rbw_red", red_count, 1);
    chk("rbw_green", green_count, 1);

    // Fill five red cells
    for (int a = 32; a < 37; a++) write_cell(a[5:0], 2'b10);
    chk("fill_red", red_count, 6);

    // Clear request together with a write: write accepted, then overwritten
    chk("pre_clear_ready", wr_ready, 1);
    wr_en     = 1'b1;
    wr_addr   = 6'h3F;
    wr_data   = 2'b10;
    clear_req = 1'b1;
    tick();
    wr_en     = 1'b0;
    clear_req = 1'b0;
    chk("clr_busy", busy, 1);
    chk("clr_red_zero", red_count, 0);
    chk("clr_ready_low", wr_ready, 0);
    run_clear(20, 0, bc, dc);
    chk("clr_busy_cycles", bc, 64);
    chk("clr_done_pulses", dc, 1);
    qry_addr = 6'h3F;
    tick();
    chk("clr_qry_3f", qry_data, 0);
    qry_addr = 6'h20;
    tick();
    chk("clr_qry_20", qry_data, 0);
    chk("clr_red", red_count, 0);
    chk("clr_green", green_count, 0);

    // Re-request ignored, reset mid-clear restarts the sequence
    write_cell(6'h01, 2'b01);
    chk("pre_rst_green", green_count, 1);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    run_clear(20, 40, bc, dc);
    chk("rst_mid_busy_cycles", bc, 64);
    chk("rst_mid_done_pulses", dc, 1);
    qry_addr = 6'h01;
    tick();
    chk("rst_mid_qry_01", qry_data, 0);
    chk("rst_mid_green", green_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
